// File: rtl/loader_pkg.sv
// loader_pkg -- shared definitions for the instruction memory loader.
//   MEM_DEPTH : default instruction memory depth in words
//   ADDR_W    : word-address width needed to index MEM_DEPTH words
//   COUNT_W   : width of the requested word count
//   state_t   : loader FSM state encoding
package loader_pkg;

    localparam int MEM_DEPTH = 8192;
    localparam int ADDR_W    = $clog2(MEM_DEPTH);
    localparam int COUNT_W   = 14;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/byte_packer.sv
// byte_packer -- assembles four bytes into one big-endian 32-bit word.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : drops any partial word and restarts at the first byte
//   in_valid    : a byte is transferred this cycle
//   in_data     : the transferred byte
//   word_valid  : high in the cycle the fourth byte arrives
//   word        : assembled word, valid while word_valid is high
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [23:0] shift_q;
    logic [1:0]  count_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            count_q <= '0;
        end else if (clear) begin
            shift_q <= '0;
            count_q <= '0;
        end else if (in_valid) begin
            shift_q <= {shift_q[15:0], in_data};
            count_q <= count_q + 2'd1;   // wraps to 0 after the fourth byte
        end
    end

    // Earlier bytes have shifted toward the top, so the first byte lands in 31:24.
    assign word_valid = in_valid && (count_q == 2'd3);
    assign word       = {shift_q, in_data};

endmodule

// File: rtl/inst_mem_loader.sv
// inst_mem_loader -- streams bytes into 32-bit words and writes them to
// consecutive instruction memory addresses.
//   clk, rst_n    : clock, asynchronous active-low reset
//   Start         : one-cycle pulse starting a load (ignored while Busy)
//   Word_Count    : words to load, sampled with Start
//   Byte_Valid    : Byte_Data holds a byte
//   Byte_Data     : incoming program byte
//   Byte_Ready    : loader accepts a byte this cycle
//   Write_Enable  : one-cycle memory write strobe
//   Write_Address : word index, wraps at MEM_DEPTH
//   Write_Data    : assembled word
//   Busy          : a load is in progress
//   Done          : one-cycle pulse at the end of a load
module inst_mem_loader
    import loader_pkg::*;
#(
    parameter int MEM_DEPTH = loader_pkg::MEM_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Start,
    input  logic [COUNT_W-1:0] Word_Count,
    input  logic               Byte_Valid,
    input  logic [7:0]         Byte_Data,
    output logic               Byte_Ready,
    output logic               Write_Enable,
    output logic [31:0]        Write_Address,
    output logic [31:0]        Write_Data,
    output logic               Busy,
    output logic               Done
);

    state_t             state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [COUNT_W-1:0] remaining_q;

    logic        start_accept;
    logic        byte_xfer;
    logic        word_valid;
    logic [31:0] word;

    assign start_accept = (state_q == IDLE) && Start;
    assign byte_xfer    = Byte_Valid && Byte_Ready;

    byte_packer u_byte_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_accept),
        .in_valid   (byte_xfer),
        .in_data    (Byte_Data),
        .word_valid (word_valid),
        .word       (word)
    );

    assign Write_Address = {{(32 - ADDR_W){1'b0}}, addr_q};

    // Outputs are registered and change together with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            Write_Data   <= '0;
            Byte_Ready   <= 1'b0;
            Write_Enable <= 1'b0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        remaining_q <= Word_Count;
                        addr_q      <= '0;
                        Busy        <= 1'b1;
                        if (Word_Count == '0) begin
                            state_q <= FINISH;
                            Done    <= 1'b1;
                        end else begin
                            state_q    <= RECV;
                            Byte_Ready <= 1'b1;
                        end
                    end
                end

                RECV: begin
                    if (word_valid) begin
                        state_q      <= WRITE;
                        Byte_Ready   <= 1'b0;
                        Write_Enable <= 1'b1;
                        Write_Data   <= word;
                    end
                end

                WRITE: begin
                    Write_Enable <= 1'b0;
                    remaining_q  <= remaining_q - COUNT_W'(1);
                    addr_q       <= (addr_q == ADDR_W'(MEM_DEPTH - 1)) ? '0
                                                                       : addr_q + ADDR_W'(1);
                    if (remaining_q == COUNT_W'(1)) begin
                        state_q <= FINISH;
                        Done    <= 1'b1;
                    end else begin
                        state_q    <= RECV;
                        Byte_Ready <= 1'b1;
                    end
                end

                FINISH: begin
                    state_q <= IDLE;
                    Done    <= 1'b0;
                    Busy    <= 1'b0;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader -- self-checking bench for inst_mem_loader.
// Expected writes come from a simple model: word i of a load goes to
// address i mod MEM_DEPTH carrying the i-th group of four bytes, big-endian.
module tb_inst_mem_loader;

    localparam int DEPTH = 8192;

    logic        clk;
    logic        rst_n;
    logic        Start;
    logic [13:0] Word_Count;
    logic        Byte_Valid;
    logic [7:0]  Byte_Data;
    logic        Byte_Ready;
    logic        Write_Enable;
    logic [31:0] Write_Address;
    logic [31:0] Write_Data;
    logic        Busy;
    logic        Done;

    inst_mem_loader #(.MEM_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .Start         (Start),
        .Word_Count    (Word_Count),
        .Byte_Valid    (Byte_Valid),
        .Byte_Data     (Byte_Data),
        .Byte_Ready    (Byte_Ready),
        .Write_Enable  (Write_Enable),
        .Write_Address (Write_Address),
        .Write_Data    (Write_Data),
        .Busy          (Busy),
        .Done          (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: samples outputs on the falling edge, away from the active edge.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t wr_q[$];
    int  cyc         = 0;
    int  last_we_cyc = 0;
    int  done_cnt    = 0;
    int  done_cyc    = 0;
    int  br_cnt      = 0;
    int  hi_bad      = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (Write_Enable) begin
            wr_q.push_back('{Write_Address, Write_Data});
            last_we_cyc <= cyc;
            if (Write_Address[31:13] != 19'd0) hi_bad <= hi_bad + 1;
        end
        if (Done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (Byte_Ready) br_cnt <= br_cnt + 1;
    end

    // Words the model expects for the current load, in order.
    logic [31:0] exp_words[$];

    // All driving happens at posedge+1.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int  n;
        bit  accepted;
        n = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
        Byte_Valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
        Byte_Valid = 1'b1;
        Byte_Data  = b;
        accepted   = 1'b0;
        for (int t = 0; t < 64 && !accepted; t++) begin
            @(negedge clk);
            if (Byte_Ready) accepted = 1'b1;
            @(posedge clk); #1;
        end
        Byte_Valid = 1'b0;
        if (!accepted) check("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start(input logic [13:0] wc);
        Start      = 1'b1;
        Word_Count = wc;
        @(posedge clk); #1;
        Start      = 1'b0;
        Word_Count = 14'($urandom);
    endtask

    // One full load of wc words taken from exp_words; exp_n is the write count required.
    task automatic run_load(input int wc, input int exp_n, input int gap, input bit mid_start);
        int  wr_base, done_base, br_base, n, bad, first_bad;
        bit  got;
        wr_base   = wr_q.size();
        done_base = done_cnt;
        br_base   = br_cnt;

        // Bytes offered while idle must not be consumed.
        Byte_Valid = 1'b1;
        Byte_Data  = 8'hEE;
        repeat (2) begin
            @(posedge clk); #1;
        end
        Byte_Valid = 1'b0;

        pulse_start(14'(wc));
        for (int i = 0; i < wc; i++) begin
            for (int j = 0; j < 4; j++) begin
                send_byte(exp_words[i][31 - 8*j -: 8], gap);
                if (mid_start && i == 0 && j == 1) pulse_start(14'd1);
            end
        end

        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(posedge clk); #1;
            if (done_cnt > done_base) got = 1'b1;
        end
        check("done_seen", 32'(got), 32'd1);
        check("busy_after_done", 32'(Busy), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
        end

        n = wr_q.size() - wr_base;
        check("write_count", n, exp_n);
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < n && i < wc; i++) begin
            if (wr_q[wr_base + i].addr !== 32'(i % DEPTH) ||
                wr_q[wr_base + i].data !== exp_words[i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        if (bad != 0)
            $display("  first bad write #%0d: addr 0x%08h data 0x%08h, model addr 0x%08h data 0x%08h",
                     first_bad, wr_q[wr_base + first_bad].addr, wr_q[wr_base + first_bad].data,
                     32'(first_bad % DEPTH), exp_words[first_bad]);
        check("write_contents", bad, 0);
        check("done_count", done_cnt - done_base, 1);
        if (wc > 0) check("done_after_last_write", done_cyc - last_we_cyc, 1);
        else        check("byte_ready_never", br_cnt - br_base, 0);
    endtask

    typedef struct {
        int          wc;
        logic [31:0] w0;
        logic [31:0] w1;
        int          gap;
        bit          mid_start;
        int          exp_writes;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int wb;

        vecs[0] = '{1, 32'h8C010004, 32'h0,        0, 1'b0, 1};
        vecs[1] = '{0, 32'h0,        32'h0,        0, 1'b0, 0};
        vecs[2] = '{2, 32'hDEADBEEF, 32'h00000001, 3, 1'b0, 2};
        vecs[3] = '{1, 32'hFFFFFFFF, 32'h0,        4, 1'b0, 1};
        vecs[4] = '{2, 32'h12345678, 32'hA5A55A5A, 0, 1'b1, 2};

        rst_n      = 1'b0;
        Start      = 1'b0;
        Word_Count = '0;
        Byte_Valid = 1'b0;
        Byte_Data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy",       32'(Busy),         32'd0);
        check("reset_byte_ready", 32'(Byte_Ready),   32'd0);
        check("reset_we",         32'(Write_Enable), 32'd0);
        check("reset_done",       32'(Done),         32'd0);
        check("reset_addr",       Write_Address,     32'd0);
        check("reset_data",       Write_Data,        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven loads.
        for (int v = 0; v < 5; v++) begin
            exp_words = {};
            if (vecs[v].wc > 0) exp_words.push_back(vecs[v].w0);
            if (vecs[v].wc > 1) exp_words.push_back(vecs[v].w1);
            run_load(vecs[v].wc, vecs[v].exp_writes, vecs[v].gap, vecs[v].mid_start);
        end

        // Randomised loads: three words with gaps, then a few random sizes,
        // one of them with a stray Start mid-load.
        for (int r = 0; r < 4; r++) begin
            int wc;
            wc = (r == 0) ? 3 : int'($urandom_range(5, 1));
            exp_words = {};
            for (int i = 0; i < wc; i++) exp_words.push_back($urandom);
            run_load(wc, wc, 5, r == 2);
        end

        // Reset in the middle of a word: nothing written, outputs cleared.
        exp_words = {};
        wb = wr_q.size();
        pulse_start(14'd1);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midreset_busy",       32'(Busy),         32'd0);
        check("midreset_byte_ready", 32'(Byte_Ready),   32'd0);
        check("midreset_addr",       Write_Address,     32'd0);
        check("midreset_data",       Write_Data,        32'd0);
        check("midreset_no_write",   wr_q.size() - wb,  0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_words.push_back(32'h00000020);
        run_load(1, 1, 0, 1'b0);

        // Address wrap: 8193 words, last one lands at address 0.
        exp_words = {};
        for (int i = 0; i < DEPTH + 1; i++) exp_words.push_back($urandom);
        run_load(DEPTH + 1, DEPTH + 1, 0, 1'b0);
        check("wrap_last_addr", wr_q[wr_q.size() - 1].addr, 32'd0);

        check("addr_high_bits_zero", hi_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
